// File: rtl/cache_line_bridge.sv
// cache_line_bridge: moves cache lines between the cache and a single-word memory bus (victim writeback and refill assembly)
//   Ports: clk, rst (sync, active-high); cache side wb_req/wb_addr/wb_line/wb_done,
//   fill_req/fill_addr/fill_line/fill_valid, busy, err; memory side mem_req/mem_we/
//   mem_addr/mem_wdata/mem_ack/mem_rdata.
//   Optional CACHE_BRIDGE_TIMEOUT_EN: abort a word wait after TIMEOUT_CYCLES and pulse err.
module cache_line_bridge #(
  parameter int LINE_BYTES = 16
`ifdef CACHE_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_req,
  input  logic [31:0]             wb_addr,
  input  logic [LINE_BYTES*8-1:0] wb_line,
  output logic                    wb_done,
  input  logic                    fill_req,
  input  logic [31:0]             fill_addr,
  output logic [LINE_BYTES*8-1:0] fill_line,
  output logic                    fill_valid,
  output logic                    busy,
  output logic                    err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata
);
  localparam int WORDS = LINE_BYTES / 4;
  localparam int CW = $clog2(WORDS);
  typedef enum logic [2:0] {IDLE, WB, FILL, DONE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic is_wb_q;
  logic [31:0] base_q;
  logic [LINE_BYTES*8-1:0] line_q, fill_q;
  logic to_hit;
  logic accept;
  assign accept = state_q == IDLE && (wb_req || fill_req);
  assign fill_line = fill_q;
`ifdef CACHE_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic err_q;
  assign to_hit = mem_req && !mem_ack && to_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    to_q <= (rst || !mem_req || mem_ack) ? '0 : to_q + 1'b1;
    err_q <= rst || state_q == IDLE ? 1'b0 : (to_hit ? 1'b1 : err_q);
  end
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = wb_req ? WB : (fill_req ? FILL : IDLE);
      WB,
      FILL:    state_d = (to_hit || (mem_ack && cnt_q == CW'(WORDS - 1))) ? DONE : state_q;
      DONE:    state_d = RELEASE;
      RELEASE: state_d = (is_wb_q ? wb_req : fill_req) ? RELEASE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    mem_req = state_q == WB || state_q == FILL;
    mem_we = state_q == WB;
    mem_addr = mem_req ? base_q + 32'({cnt_q, 2'b00}) : 32'h0;
    mem_wdata = mem_we ? line_q[32*cnt_q +: 32] : 32'h0;
    wb_done = state_q == DONE && is_wb_q;
    fill_valid = state_q == DONE && !is_wb_q;
`ifdef CACHE_BRIDGE_TIMEOUT_EN
    err = state_q == DONE && err_q;
`else
    err = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      is_wb_q <= 1'b0;
      base_q <= 32'h0;
      line_q <= '0;
      fill_q <= '0;
    end else begin
      if (accept) begin
        is_wb_q <= wb_req;
        base_q <= (wb_req ? wb_addr : fill_addr) & ~32'(LINE_BYTES - 1);
        if (wb_req) line_q <= wb_line;
        else fill_q <= '0;
      end
      if (mem_req && mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
        if (state_q == FILL) fill_q[32*cnt_q +: 32] <= mem_rdata;
      end
      // a timed-out burst leaves DONE with a partial count
      if (state_q == DONE) cnt_q <= '0;
    end
  end
endmodule

// File: tb/tb_cache_line_bridge.sv
// tb_cache_line_bridge: randomized bench with a word-memory model and line-level expectations
module tb_cache_line_bridge;
  localparam int LB = 16;
  localparam int W = LB / 4;
`ifdef CACHE_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`endif
  logic clk = 0, rst = 1, wb_req = 0, fill_req = 0, mem_ack = 0;
  logic [31:0] wb_addr = 0, fill_addr = 0, mem_rdata = 0;
  logic [LB*8-1:0] wb_line = 0;
  logic [LB*8-1:0] fill_line;
  logic wb_done, fill_valid, busy, err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  int n_chk = 0, n_err = 0, waits = 0, req_cycles = 0;
  bit ack_off = 0, noise = 0;
  bit [31:0] mem [bit [31:0]];
  logic [31:0] q_addr[$], q_data[$];
  bit q_we[$];
  logic [LB*8-1:0] last_fill = 0;

  cache_line_bridge #(.LINE_BYTES(LB)
`ifdef CACHE_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
    .wb_done(wb_done), .fill_req(fill_req), .fill_addr(fill_addr), .fill_line(fill_line),
    .fill_valid(fill_valid), .busy(busy), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LB*8-1:0] model_line(input logic [31:0] base);
    logic [LB*8-1:0] l;
    for (int k = 0; k < W; k++) l[32*k +: 32] = rd_word(base + 32'(4*k));
    return l;
  endfunction

  task automatic clear_q();
    q_addr.delete(); q_data.delete(); q_we.delete();
  endtask

  // memory: acks each word after `waits` idle cycles; random acks while idle when noise is on
  initial begin
    int wl;
    wl = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !ack_off) begin
        if (wl >= waits) begin mem_ack = 1; mem_rdata = rd_word(mem_addr); wl = 0; end
        else begin mem_ack = 0; mem_rdata = $urandom; wl++; end
      end else begin
        mem_ack = noise && ($urandom_range(0, 1) == 1);
        mem_rdata = $urandom;
        wl = 0;
      end
    end
  end

  // bus monitor: logs accepted words and checks the request is held while stalled
  initial begin
    logic [31:0] pa, pd;
    bit pw, hold;
    hold = 0; pa = 0; pd = 0; pw = 0;
    forever begin
      @(negedge clk); #1;
      if (mem_req) begin
        req_cycles++;
        if (hold) begin
          chk("hold_addr", mem_addr, pa);
          chk("hold_we", mem_we, pw);
          if (mem_we) chk("hold_wdata", mem_wdata, pd);
        end
      end
      hold = mem_req && !mem_ack; pa = mem_addr; pw = mem_we; pd = mem_wdata;
      if (mem_req && mem_ack) begin
        q_addr.push_back(mem_addr); q_we.push_back(mem_we);
        q_data.push_back(mem_we ? mem_wdata : mem_rdata);
      end
    end
  end

  task automatic do_op(input bit is_wb, input logic [31:0] a, input logic [LB*8-1:0] line, input int w);
    logic [31:0] base;
    logic [LB*8-1:0] exp_fill;
    int c;
    bit seen;
    base = a & ~32'(LB - 1);
    waits = w;
    clear_q();
    @(negedge clk);
    if (is_wb) begin wb_req = 1; wb_addr = a; wb_line = line; end
    else begin fill_req = 1; fill_addr = a; end
    seen = 0;
    for (c = 1; c <= 400; c++) begin
      @(negedge clk); #2;
      if (wb_done || fill_valid) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    chk("latency", c, W * (w + 1) + 1);
    chk("done_kind", {wb_done, fill_valid, err}, {is_wb, !is_wb, 1'b0});
    chk("n_words", q_addr.size(), W);
    exp_fill = model_line(base);
    for (int k = 0; k < W && k < q_addr.size(); k++) begin
      chk("w_addr", q_addr[k], base + 32'(4*k));
      chk("w_we", q_we[k], is_wb);
      chk("w_data", q_data[k], is_wb ? line[32*k +: 32] : exp_fill[32*k +: 32]);
    end
    if (!is_wb) last_fill = exp_fill;
    chk(is_wb ? "fill_stable" : "fill_line", fill_line, last_fill);
    @(negedge clk); #2;
    chk("one_pulse", {wb_done, fill_valid}, 0);
    chk("release_busy", busy, 1);
    wb_req = 0; fill_req = 0;
    @(negedge clk); #2;
    chk("back_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, fv;
    bit seen;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_memreq", {mem_req, mem_we}, 0);
    chk("rst_pulses", {wb_done, fill_valid, err}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fill", fill_line, 0);
    rst = 0;

    do_op(1, 32'h0000_1234, 128'h44444444_33333333_22222222_11111111, 0);
    for (int k = 0; k < W; k++) mem[32'h8000 + 32'(4*k)] = 32'hA0 + 32'(k);
    do_op(0, 32'h0000_8000, '0, 2);
    chk("t3_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);

    // simultaneous requests: writeback first, then fill
    waits = 0; clear_q();
    @(negedge clk);
    wb_req = 1; fill_req = 1; wb_addr = 32'h2004; fill_addr = 32'h3010;
    wb_line = {$urandom, $urandom, $urandom, $urandom};
    seen = 0;
    for (c = 0; c < 100; c++) begin @(negedge clk); #2; if (wb_done) begin seen = 1; break; end end
    chk("both_wb_done", seen, 1);
    chk("both_no_fv", fill_valid, 0);
    wb_req = 0;
    seen = 0;
    for (c = 0; c < 100; c++) begin @(negedge clk); #2; if (fill_valid) begin seen = 1; break; end end
    chk("both_fill_done", seen, 1);
    fill_req = 0;
    chk("both_n", q_addr.size(), 2 * W);
    for (int k = 0; k < 2 * W && k < q_addr.size(); k++) begin
      chk("both_we", q_we[k], k < W);
      chk("both_addr", q_addr[k], (k < W ? 32'h2000 : 32'h3010) + 32'(4 * (k % W)));
    end
    last_fill = model_line(32'h3010);
    chk("both_line", fill_line, last_fill);
    repeat (2) @(negedge clk);
    #2;
    chk("both_idle", busy, 0);

    // reset while the second fill word is stalled
    waits = 3; clear_q();
    @(negedge clk);
    fill_req = 1; fill_addr = 32'h4000;
    for (c = 0; c < 100 && q_addr.size() < 1; c++) begin @(negedge clk); #2; end
    chk("rst_first_word", q_addr.size(), 1);
    @(negedge clk); #2;
    chk("rst_pending", mem_req && !mem_ack, 1);
    rst = 1; fill_req = 0;
    @(negedge clk); #2;
    chk("abort_memreq", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fill", fill_line, 0);
    rst = 0;
    last_fill = 0;
    fv = 0;
    repeat (6) begin @(negedge clk); #2; fv += int'(fill_valid); end
    chk("abort_no_fv", fv, 0);
    chk("abort_words", q_addr.size(), 1);

`ifdef CACHE_BRIDGE_TIMEOUT_EN
    ack_off = 1;
    @(negedge clk);
    fill_req = 1; fill_addr = 32'h5000; req_cycles = 0;
    seen = 0;
    for (c = 1; c <= 100; c++) begin @(negedge clk); #2; if (fill_valid) begin seen = 1; break; end end
    chk("to_seen", seen, 1);
    chk("to_latency", c, TO + 1);
    chk("to_err", err, 1);
    chk("to_req_cycles", req_cycles, TO);
    chk("to_fill", fill_line, 0);
    @(negedge clk); #2;
    chk("to_err_pulse", err, 0);
    fill_req = 0; ack_off = 0;
    repeat (2) @(negedge clk);
`endif

    noise = 1;
    for (int i = 0; i < 24; i++) begin
      do_op($urandom_range(0, 1) == 1, $urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
